// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-to-serial 8N1 UART transmitter (8E1/8O1 with UART_TX_PARITY_EN defined)
// Ports: clk, rst (async, active-high); TxData[7:0], XMitGo (driver handshake in);
// TxEmpty (idle/ready), TxOut (serial line, idles high), TxState[2:0] (FSM state) out.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] TxData,
  input  logic       XMitGo,
  output logic       TxEmpty,
  output logic       TxOut,
  output logic [2:0] TxState
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  logic par;
`endif
  if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2 and PARITY_ODD 0 or 1");
  end
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic tx_out, tx_empty, term, busy;
  assign term = cnt == CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  assign busy = state == START || state == DATA || state == PARITY || state == STOP;
`else
  assign busy = state == START || state == DATA || state == STOP;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx_out <= 1'b1;
      tx_empty <= 1'b1;
      cnt <= '0;
      idx <= 3'd0;
      shreg <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      cnt <= (busy && !term) ? cnt + CW'(1) : '0;
      case (state)
        IDLE: if (XMitGo) begin
          shreg <= TxData;
          state <= START;
          tx_out <= 1'b0;
          tx_empty <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par <= ^TxData ^ PARITY_ODD[0];
`endif
        end
        START: if (term) begin
          state <= DATA;
          idx <= 3'd0;
          tx_out <= shreg[0];
        end
        DATA: if (term) begin
          shreg <= shreg >> 1;
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx_out <= par;
`else
            state <= STOP;
            tx_out <= 1'b1;
`endif
          end else tx_out <= shreg[1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (term) begin
          state <= STOP;
          tx_out <= 1'b1;
        end
`endif
        STOP: if (term) begin
          state <= IDLE;
          tx_empty <= 1'b1;
          idx <= 3'd0;
        end
        default: begin
          state <= IDLE;
          tx_out <= 1'b1;
          tx_empty <= 1'b1;
          idx <= 3'd0;
        end
      endcase
    end
  end
  assign TxEmpty = tx_empty;
  assign TxOut = tx_out;
  assign TxState = state;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: table-driven self-checking bench for uart_tx_serializer at CLKS_PER_BIT=4
module tb_uart_tx_serializer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = (PAR ? 11 : 10) * CPB;
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic par;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, XMitGo = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic TxEmpty, TxOut;
  logic [2:0] TxState;
  int n_chk = 0, n_fail = 0;
  vec_t vecs[6];
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .TxData(TxData), .XMitGo(XMitGo),
    .TxEmpty(TxEmpty), .TxOut(TxOut), .TxState(TxState)
  );
`ifdef UART_TX_PARITY_EN
  logic o_empty, o_out;
  logic [2:0] o_state;
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .TxData(TxData), .XMitGo(XMitGo),
    .TxEmpty(o_empty), .TxOut(o_out), .TxState(o_state)
  );
`endif
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle_check(input string name);
    check({name, "_txout"}, 8'(TxOut), 8'd1);
    check({name, "_txempty"}, 8'(TxEmpty), 8'd1);
    check({name, "_txstate"}, 8'(TxState), 8'd0);
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    TxData = d;
    XMitGo = 1'b1;
    @(negedge clk);
    XMitGo = 1'b0;
  endtask
  task automatic watch(input vec_t v, input int poke);
    int b;
    logic e;
    logic [2:0] s;
    string tag;
    for (int c = 0; c < FL; c++) begin
      b = c / CPB;
      e = (b < 9) ? v.frame[9-b] : (PAR && b == 9) ? v.par : 1'b1;
      s = (b == 0) ? 3'd1 : (b < 9) ? 3'd2 : (PAR && b == 9) ? 3'd3 : 3'd4;
      tag = $sformatf("%02h_c%0d", v.data, c);
      check({"txout_", tag}, 8'(TxOut), 8'(e));
      check({"txempty_", tag}, 8'(TxEmpty), 8'd0);
      check({"txstate_", tag}, 8'(TxState), 8'(s));
`ifdef UART_TX_PARITY_EN
      check({"odd_txout_", tag}, 8'(o_out), 8'((b == 9) ? ~v.par : e));
`endif
      if (poke >= 0 && c == poke) begin
        TxData = 8'hFF;
        XMitGo = 1'b1;
      end else if (poke >= 0 && c == poke + 1) XMitGo = 1'b0;
      @(negedge clk);
    end
    idle_check($sformatf("end_%02h", v.data));
  endtask
  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[2] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[3] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[4] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[5] = '{8'h07, 10'b0111000001, 1'b1};
    #30 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_check($sformatf("reset_hold%0d", k));
    end
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      watch(vecs[i], -1);
    end
    send(8'h3C);
    watch(vecs[1], 12);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_check($sformatf("busy_nosecond%0d", k));
    end
    @(negedge clk);
    TxData = 8'h00;
    XMitGo = 1'b1;
    @(negedge clk);
    TxData = 8'hFF;
    watch(vecs[2], -1);
    @(negedge clk);
    XMitGo = 1'b0;
    watch(vecs[3], -1);
    send(8'hA5);
    repeat (17) @(negedge clk);
    check("midframe_state_before_rst", 8'(TxState), 8'd2);
    #2 rst = 1'b1;
    #1 idle_check("async_rst");
`ifdef UART_TX_PARITY_EN
    check("async_rst_odd_txout", 8'(o_out), 8'd1);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle_check("after_rst");
    send(8'h81);
    watch(vecs[4], -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
